// File: rtl/loop_controller_if.sv
// Host/datapath handshake and control strobes of the two-phase loop controller.
// The master drives start/in_valid; the slave (controller) drives everything else.
interface loop_controller_if #(
  parameter int IDX_W = 10
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             category;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_loop;
  logic             load_a_en;
  logic             load_b_en;
  logic             load_c_en;
  logic             store_ab;
  logic             store_c_en;
  logic             mul_en;
  logic             add_en;
  logic [1:0]       mul_sel;
  logic [1:0]       add_sel;

  modport master (
    output start, in_valid,
    input  in_ready, busy, done, category, index, index_loop,
           load_a_en, load_b_en, load_c_en, store_ab, store_c_en,
           mul_en, add_en, mul_sel, add_sel
  );

  modport slave (
    input  start, in_valid,
    output in_ready, busy, done, category, index, index_loop,
           load_a_en, load_b_en, load_c_en, store_ab, store_c_en,
           mul_en, add_en, mul_sel, add_sel
  );
endinterface

// File: rtl/loop_controller.sv
// Sequencer for c[i] = a[i] + 2*b[i], then c[i] = c[i]*(a[i] + 5*b[i]), i = 0..N-1.
// Loads a[]/b[] from the host, then drives one SRAM/ALU action per cycle.
module loop_controller #(
  parameter int N     = 100,
  parameter int IDX_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  loop_controller_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, LD_A, LD_B,
    P1_LA, P1_LB, P1_MUL, P1_ADD, P1_ST,
    P2_LA, P2_LB, P2_LC, P2_MUL5, P2_ADD, P2_MULC, P2_ST,
    DONE
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       in_ready;
    logic       category;
    logic       load_a;
    logic       load_b;
    logic       load_c;
    logic       store_c;
    logic       mul_en;
    logic       add_en;
    logic [1:0] mul_sel;
    logic [1:0] add_sel;
  } ctrl_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  logic [IDX_W-1:0] idx_ab;
  logic [IDX_W-1:0] idx_loop;
  logic             accept;
  logic             last_ab;
  logic             last_loop;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      LD_A:    c.in_ready = 1'b1;
      LD_B:    begin c.in_ready = 1'b1; c.category = 1'b1; end
      P1_LA,
      P2_LA:   c.load_a = 1'b1;
      P1_LB,
      P2_LB:   c.load_b = 1'b1;
      P2_LC:   c.load_c = 1'b1;
      P1_MUL:  begin c.mul_en = 1'b1; c.mul_sel = 2'b01; end
      P1_ADD:  begin c.add_en = 1'b1; c.add_sel = 2'b01; end
      P1_ST:   c.store_c = 1'b1;
      P2_MUL5: begin c.mul_en = 1'b1; c.mul_sel = 2'b10; end
      P2_ADD:  begin c.add_en = 1'b1; c.add_sel = 2'b10; end
      P2_MULC: begin c.mul_en = 1'b1; c.mul_sel = 2'b11; end
      // The datapath muxes the product onto the store bus using mul_sel.
      P2_ST:   begin c.store_c = 1'b1; c.mul_sel = 2'b11; end
      DONE:    c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  assign accept    = ctrl.in_ready & bus.in_valid;
  assign last_ab   = (idx_ab == LAST);
  assign last_loop = (idx_loop == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LD_A;
      LD_A:    if (accept && last_ab) state_nxt = LD_B;
      LD_B:    if (accept && last_ab) state_nxt = P1_LA;
      P1_LA:   state_nxt = P1_LB;
      P1_LB:   state_nxt = P1_MUL;
      P1_MUL:  state_nxt = P1_ADD;
      P1_ADD:  state_nxt = P1_ST;
      P1_ST:   state_nxt = last_loop ? P2_LA : P1_LA;
      P2_LA:   state_nxt = P2_LB;
      P2_LB:   state_nxt = P2_LC;
      P2_LC:   state_nxt = P2_MUL5;
      P2_MUL5: state_nxt = P2_ADD;
      P2_ADD:  state_nxt = P2_MULC;
      P2_MULC: state_nxt = P2_ST;
      P2_ST:   state_nxt = last_loop ? DONE : P2_LA;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      idx_ab   <= '0;
      idx_loop <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
      case (state)
        IDLE:        if (bus.start) idx_ab <= '0;
        LD_A, LD_B:  if (accept) idx_ab <= last_ab ? '0 : idx_ab + IDX_W'(1);
        P1_ST, P2_ST: idx_loop <= last_loop ? '0 : idx_loop + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = ctrl.in_ready;
  assign bus.busy       = ctrl.busy;
  assign bus.done       = ctrl.done;
  assign bus.category   = ctrl.category;
  assign bus.index      = idx_ab;
  assign bus.index_loop = idx_loop;
  assign bus.load_a_en  = ctrl.load_a;
  assign bus.load_b_en  = ctrl.load_b;
  assign bus.load_c_en  = ctrl.load_c;
  assign bus.store_ab   = accept;
  assign bus.store_c_en = ctrl.store_c;
  assign bus.mul_en     = ctrl.mul_en;
  assign bus.add_en     = ctrl.add_en;
  assign bus.mul_sel    = ctrl.mul_sel;
  assign bus.add_sel    = ctrl.add_sel;

endmodule

// File: tb/tb_loop_controller.sv
// Directed bench for loop_controller (N=4) with a small datapath/SRAM model.
// Output word layout: {busy,done,in_ready,store_ab,category,la,lb,lc,sc,mul_en,add_en,mul_sel,add_sel}.
module tb_loop_controller;
  localparam int N     = 4;
  localparam int IDX_W = 10;

  localparam logic [14:0] W_LDA  = 15'h5800;
  localparam logic [14:0] W_LDB  = 15'h5C00;
  localparam logic [14:0] W_DONE = 15'h6000;
  localparam logic [14:0] P1_TBL [5] = '{15'h4200, 15'h4100, 15'h4024, 15'h4011, 15'h4040};
  localparam logic [14:0] P2_TBL [7] = '{15'h4200, 15'h4100, 15'h4080, 15'h4028,
                                         15'h4012, 15'h402C, 15'h404C};
  localparam int C_EXP [4] = '{18, 28, 91, 16};

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc;
  int   obs_cyc;
  int   acc;
  int   done_at;
  int   words [8] = '{1, 2, 3, 4, 1, 1, 2, 0};
  int   ma [4];
  int   mb [4];
  int   mc [4];
  int   ra, rb, rc, mr, ar;
  logic [14:0]      obs_w;
  logic [IDX_W-1:0] obs_idx;
  logic [IDX_W-1:0] obs_loop;

  loop_controller_if #(.IDX_W(IDX_W)) bus ();

  loop_controller #(.N(N), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_word(input int r);
    if (r >= 1 && r <= 4)   return W_LDA;
    if (r >= 5 && r <= 8)   return W_LDB;
    if (r >= 9 && r <= 28)  return P1_TBL[(r - 9) % 5];
    if (r >= 29 && r <= 56) return P2_TBL[(r - 29) % 7];
    if (r == 57)            return W_DONE;
    return 15'h0000;
  endfunction

  function automatic int exp_idx(input int r);
    if (r >= 1 && r <= 4) return r - 1;
    if (r >= 5 && r <= 8) return r - 5;
    return 0;
  endfunction

  function automatic int exp_loop(input int r);
    if (r >= 9 && r <= 28)  return (r - 9) / 5;
    if (r >= 29 && r <= 56) return (r - 29) / 7;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, obs_cyc, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic r);
    int il;
    int ix;
    bus.start    = s;
    bus.in_valid = v;
    rst          = r;
    @(negedge clk);
    obs_cyc  = cyc;
    obs_w    = {bus.busy, bus.done, bus.in_ready, bus.store_ab, bus.category,
                bus.load_a_en, bus.load_b_en, bus.load_c_en, bus.store_c_en,
                bus.mul_en, bus.add_en, bus.mul_sel, bus.add_sel};
    obs_idx  = bus.index;
    obs_loop = bus.index_loop;
    total++;
    assert ($countones({bus.load_a_en, bus.load_b_en, bus.load_c_en, bus.store_ab,
                        bus.store_c_en, bus.mul_en, bus.add_en}) <= 1) else begin
      bad++;
      $error("FAIL onehot cyc=%0d got=%0h want=at most one strobe", obs_cyc, obs_w);
    end
    il = int'(bus.index_loop) % 4;
    ix = int'(bus.index) % 4;
    if (bus.store_ab) begin
      if (bus.category) mb[ix] = words[acc % 8];
      else              ma[ix] = words[acc % 8];
      acc++;
    end
    if (bus.load_a_en) ra = ma[il];
    if (bus.load_b_en) rb = mb[il];
    if (bus.load_c_en) rc = mc[il];
    if (bus.mul_en) begin
      case (bus.mul_sel)
        2'b01:   mr = rb * 2;
        2'b10:   mr = rb * 5;
        2'b11:   mr = rc * ar;
        default: ;
      endcase
    end
    if (bus.add_en && bus.add_sel != 2'b00) ar = ra + mr;
    if (bus.store_c_en) mc[il] = (bus.mul_sel == 2'b11) ? mr : ar;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_c(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, mc[i], C_EXP[i]);
  endtask

  task automatic run_std(input string tag);
    cyc = 0;
    acc = 0;
    for (int c = 0; c < 60; c++) begin
      step(c == 0, 1'b1, 1'b0);
      chk({tag, ".word"}, obs_w, exp_word(c));
      chk({tag, ".index"}, obs_idx, exp_idx(c));
      chk({tag, ".index_loop"}, obs_loop, exp_loop(c));
    end
    chk_c({tag, ".c"});
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    ra = 0; rb = 0; rc = 0; mr = 0; ar = 0; acc = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rst.word", obs_w, 15'h0000);
      chk("rst.index", obs_idx, 0);
      chk("rst.index_loop", obs_loop, 0);
    end

    // scenarios 1, 2, 4: continuous in_valid, full timing and final c[]
    run_std("s12");

    // scenario 3: in_valid toggling during the load
    cyc = 0;
    acc = 0;
    for (int c = 0; c <= 16; c++) begin
      logic v;
      logic [14:0] w;
      int ei;
      v  = (c % 2 == 1);
      step(c == 0, v, 1'b0);
      if (c == 0)       w = 15'h0000;
      else if (c == 16) w = 15'h4200;
      else              w = 15'h5000 | (v ? 15'h0800 : 15'h0000) | (c >= 8 ? 15'h0400 : 15'h0000);
      if (c < 8)        ei = c / 2;
      else if (c < 16)  ei = (c - 8) / 2;
      else              ei = 0;
      chk("s3.word", obs_w, w);
      chk("s3.index", obs_idx, ei);
    end
    done_at = -1;
    for (int c = 17; c < 80; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (obs_w[13] && done_at < 0) done_at = c;
    end
    chk("s3.done_at", done_at, 64);
    chk_c("s3.c");

    // scenario 5: reset during P2_MULC of element 2, then a fresh run
    cyc = 0;
    acc = 0;
    for (int c = 0; c <= 48; c++) begin
      step(c == 0, 1'b1, c == 48);
      chk("s5.word", obs_w, exp_word(c));
      chk("s5.index_loop", obs_loop, exp_loop(c));
    end
    for (int c = 49; c < 52; c++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("s5.post.word", obs_w, 15'h0000);
      chk("s5.post.index_loop", obs_loop, 0);
      chk("s5.post.index", obs_idx, 0);
    end
    run_std("s5.rerun");

    // reset in the middle of the a[] load
    cyc = 0;
    acc = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ldrst.c1.word", obs_w, W_LDA);
    step(1'b0, 1'b1, 1'b1);
    chk("ldrst.c2.index", obs_idx, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("ldrst.c3.word", obs_w, 15'h0000);
    chk("ldrst.c3.index", obs_idx, 0);
    step(1'b0, 1'b1, 1'b0);
    chk("ldrst.c4.word", obs_w, 15'h0000);

    // scenario 6: start held high; back-to-back runs with one IDLE cycle between
    cyc = 0;
    acc = 0;
    for (int c = 0; c <= 116; c++) begin
      int r;
      r = (c < 58) ? c : c - 58;
      step(1'b1, 1'b1, 1'b0);
      chk("s6.word", obs_w, exp_word(r));
      chk("s6.index_loop", obs_loop, exp_loop(r));
    end
    chk_c("s6.c");

    step(1'b0, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
